// File: rtl/sbox_init_engine_pkg.sv
// Shared types and constants for the S-box RAM initialiser: state encoding
// (also exported on state_tap) and fill-pattern mode codes.
package sbox_init_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_VERIFY = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        M_IDENTITY = 2'd0,
        M_DESCEND  = 2'd1,
        M_CONST    = 2'd2,
        M_RESERVED = 2'd3
    } mode_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_VERIFY = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] MODE_IDENTITY = 2'd0;
    localparam logic [1:0] MODE_DESCEND  = 2'd1;
    localparam logic [1:0] MODE_CONST    = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;

endpackage

// File: rtl/sbox_init_engine_if.sv
// Control handshake plus S-box RAM port of the initialiser. The engine uses the
// slave view; the control FSM / RAM mux side uses the master view.
interface sbox_init_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [DATA_W-1:0] fill_value;
    logic              verify_en;
    logic [DATA_W-1:0] ram_out;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] ram_in;
    logic              write_enable;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] err_addr;
    logic [2:0]        state_tap;

    modport slave (
        input  start, abort, mode, fill_value, verify_en, ram_out,
        output address, ram_in, write_enable, busy, done, error, err_addr, state_tap
    );

    modport master (
        output start, abort, mode, fill_value, verify_en, ram_out,
        input  address, ram_in, write_enable, busy, done, error, err_addr, state_tap
    );
endinterface

// File: rtl/sbox_init_engine_verify_pipe.sv
// Read-back checker: carries expected data/address alongside the RAM read latency
// and records the first address whose read data disagrees.
module init_verify_pipe #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              clear_err,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_exp,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] ram_out,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    logic [RD_LAT-1:0] vld_r;
    logic [DATA_W-1:0] exp_r  [RD_LAT];
    logic [ADDR_W-1:0] addr_r [RD_LAT];
    logic              error_r;
    logic [ADDR_W-1:0] err_addr_r;
    logic              hit_s;

    // Mismatch at the stage whose read data is arriving this cycle
    always_comb begin
        hit_s = vld_r[RD_LAT-1] && (ram_out != exp_r[RD_LAT-1]);
    end

    // Expected-value shift register; a flush drops in-flight compares
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                exp_r[i]  <= {DATA_W{1'b0}};
                addr_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            vld_r[0]  <= in_valid && !flush;
            exp_r[0]  <= in_exp;
            addr_r[0] <= in_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_r[i]  <= vld_r[i-1] && !flush;
                exp_r[i]  <= exp_r[i-1];
                addr_r[i] <= addr_r[i-1];
            end
        end
    end

    // Sticky first-mismatch capture, cleared only when a new operation starts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_r    <= 1'b0;
            err_addr_r <= {ADDR_W{1'b0}};
        end else if (clear_err) begin
            error_r    <= 1'b0;
            err_addr_r <= {ADDR_W{1'b0}};
        end else if (hit_s && !error_r) begin
            error_r    <= 1'b1;
            err_addr_r <= addr_r[RD_LAT-1];
        end
    end

    assign error    = error_r;
    assign err_addr = err_addr_r;

endmodule

// File: rtl/sbox_init_engine.sv
// S-box RAM initialiser: fills DEPTH words with a selectable pattern, optionally
// reads them back, and reports completion over a four-phase start/done handshake.
module sbox_init_engine
    import sbox_init_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    sbox_init_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE    = ADDR_W'(1);

    logic [2:0]        state_r, state_s;
    logic [ADDR_W-1:0] cnt_r, cnt_s;
    logic [1:0]        mode_r, mode_sel_s;
    logic [DATA_W-1:0] fill_r, fill_sel_s;
    logic              verify_r;
    logic              start_op_s;
    logic              abort_op_s;
    logic [ADDR_W-1:0] address_r;
    logic [DATA_W-1:0] ram_in_r;
    logic              we_r;
    logic              busy_r;
    logic              done_r;
    logic              pipe_valid_s;
    logic [DATA_W-1:0] pipe_exp_s;

    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] fill
    );
        case (m)
            MODE_DESCEND: pattern = DATA_W'(32'(DEPTH - 1) - 32'(idx));
            MODE_CONST:   pattern = fill;
            default:      pattern = DATA_W'(idx);
        endcase
    endfunction

    // Next-state and counter; abort overrides everything outside IDLE
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        start_op_s = 1'b0;
        abort_op_s = 1'b0;
        if ((state_r != ST_IDLE) && bus.abort) begin
            state_s    = ST_IDLE;
            cnt_s      = {ADDR_W{1'b0}};
            abort_op_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_s    = ST_WRITE;
                        cnt_s      = {ADDR_W{1'b0}};
                        start_op_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (cnt_r == LAST_IDX) begin
                        cnt_s   = {ADDR_W{1'b0}};
                        state_s = verify_r ? ST_VERIFY : ST_DONE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_VERIFY: begin
                    if (cnt_r == LAST_IDX) begin
                        cnt_s   = {ADDR_W{1'b0}};
                        state_s = ST_DRAIN;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_r == DRAIN_LAST) begin
                        cnt_s   = {ADDR_W{1'b0}};
                        state_s = ST_DONE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (!bus.start) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // On the accepting edge the first word must use the incoming settings
    always_comb begin
        if (start_op_s) begin
            mode_sel_s = bus.mode;
            fill_sel_s = bus.fill_value;
        end else begin
            mode_sel_s = mode_r;
            fill_sel_s = fill_r;
        end
    end

    // Verify reads enter the compare pipe alongside the address being presented
    always_comb begin
        pipe_valid_s = (state_r == ST_VERIFY);
        pipe_exp_s   = pattern(mode_r, cnt_r, fill_r);
    end

    // State, counter and latched operation settings
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {ADDR_W{1'b0}};
            mode_r   <= MODE_IDENTITY;
            fill_r   <= {DATA_W{1'b0}};
            verify_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (start_op_s) begin
                mode_r   <= bus.mode;
                fill_r   <= bus.fill_value;
                verify_r <= bus.verify_en;
            end
        end
    end

    // Outputs are registered from the next state so strobes align with transitions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address_r <= {ADDR_W{1'b0}};
            ram_in_r  <= {DATA_W{1'b0}};
            we_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            we_r   <= (state_s == ST_WRITE);
            busy_r <= (state_s == ST_WRITE) || (state_s == ST_VERIFY);
            done_r <= (state_s == ST_DONE);
            if ((state_s == ST_WRITE) || (state_s == ST_VERIFY)) begin
                address_r <= cnt_s;
            end else begin
                address_r <= {ADDR_W{1'b0}};
            end
            if (state_s == ST_WRITE) begin
                ram_in_r <= pattern(mode_sel_s, cnt_s, fill_sel_s);
            end else begin
                ram_in_r <= {DATA_W{1'b0}};
            end
        end
    end

    init_verify_pipe #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_verify_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (abort_op_s),
        .clear_err (start_op_s),
        .in_valid  (pipe_valid_s),
        .in_exp    (pipe_exp_s),
        .in_addr   (cnt_r),
        .ram_out   (bus.ram_out),
        .error     (bus.error),
        .err_addr  (bus.err_addr)
    );

    assign bus.address      = address_r;
    assign bus.ram_in       = ram_in_r;
    assign bus.write_enable = we_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.state_tap    = state_r;

endmodule
